instr_reg_scheduler: RTL

Sequences the instruction register as a circular instruction queue. It round-robin arbitrates NREQ writers onto the single register load port and owns write_pointer and read_pointer. It serves one reader with a request/grant port and returns the instruction word with fixed latency. It sits between the producers and the instruction register, and drives every register control signal.

---
 rtl/instr_reg_scheduler.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/instr_reg_scheduler.sv
// Front-end sequencer for a circular instruction register: round-robin write
// arbitration, write/read pointer ownership and a fixed-latency read port.
module instr_reg_scheduler #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 5,
  parameter int OP_W   = 4,
  parameter int DATA_W = 32,
  parameter int IW_W   = 68
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [NREQ-1:0]        wr_req,
  input  logic [NREQ*OP_W-1:0]   wr_opcode,
  input  logic [NREQ*DATA_W-1:0] wr_operand_a,
  input  logic [NREQ*DATA_W-1:0] wr_operand_b,
  output logic [NREQ-1:0]        wr_gnt,
  input  logic                   rd_req,
  output logic                   rd_gnt,
  output logic                   rd_valid,
  output logic [IW_W-1:0]        rd_instr,
  output logic                   ir_load_en,
  output logic [OP_W-1:0]        ir_opcode,
  output logic [DATA_W-1:0]      ir_operand_a,
  output logic [DATA_W-1:0]      ir_operand_b,
  output logic [ADDR_W-1:0]      ir_write_pointer,
  output logic [ADDR_W-1:0]      ir_read_pointer,
  input  logic [IW_W-1:0]        ir_instruction_word,
  output logic [ADDR_W:0]        count,
  output logic                   full,
  output logic                   empty
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [ADDR_W:0]  DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(NREQ - 1);

  // Handshake: a requester holds req and its data until it sees gnt in the same
  // cycle; a grant is a transfer. rd_gnt likewise accepts the reader's request,
  // and rd_valid is a one-cycle pulse two cycles later carrying the word.

  logic [ADDR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ADDR_W:0]   count_q, count_d, avail_q, avail_d;
  logic [IDX_W-1:0]  last_gnt_q, gnt_idx, cand;
  logic              gnt_found, wr_fire, rd_fire;
  logic              rd_pend_q, rd_valid_q, ir_load_en_q;
  logic [IW_W-1:0]   rd_instr_q;
  logic [OP_W-1:0]   ir_opcode_q;
  logic [DATA_W-1:0] ir_operand_a_q, ir_operand_b_q;
  logic [ADDR_W-1:0] ir_write_pointer_q, ir_read_pointer_q;

  assign full    = (count_q == DEPTH_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_fire = !reset && !flush && rd_req && (avail_q != '0);
  assign rd_gnt  = rd_fire;
  assign wr_fire = gnt_found;

  assign rd_valid         = rd_valid_q;
  assign rd_instr         = rd_instr_q;
  assign ir_load_en       = ir_load_en_q;
  assign ir_opcode        = ir_opcode_q;
  assign ir_operand_a     = ir_operand_a_q;
  assign ir_operand_b     = ir_operand_b_q;
  assign ir_write_pointer = ir_write_pointer_q;
  assign ir_read_pointer  = ir_read_pointer_q;

  // Round-robin: the search begins one past the previous winner.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = last_gnt_q;
    cand      = '0;
    wr_gnt    = '0;
    if (!reset && !full && !flush) begin
      for (int k = 1; k <= NREQ; k++) begin
        cand = IDX_W'((int'(last_gnt_q) + k) % NREQ);
        if (!gnt_found && wr_req[cand]) begin
          gnt_found = 1'b1;
          gnt_idx   = cand;
        end
      end
    end
    if (gnt_found) wr_gnt[gnt_idx] = 1'b1;
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    avail_d = avail_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      avail_d = '0;
    end else begin
      if (wr_fire) wptr_d = wptr_q + 1'b1;
      if (rd_fire) rptr_d = rptr_q + 1'b1;
      case ({wr_fire, rd_fire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      // An entry is readable only once its load cycle has completed.
      if (ir_load_en_q) avail_d = avail_d + 1'b1;
      if (rd_fire)      avail_d = avail_d - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q             <= '0;
      rptr_q             <= '0;
      count_q            <= '0;
      avail_q            <= '0;
      last_gnt_q         <= LAST_RST;
      ir_load_en_q       <= 1'b0;
      ir_opcode_q        <= '0;
      ir_operand_a_q     <= '0;
      ir_operand_b_q     <= '0;
      ir_write_pointer_q <= '0;
      ir_read_pointer_q  <= '0;
      rd_pend_q          <= 1'b0;
      rd_valid_q         <= 1'b0;
      rd_instr_q         <= '0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      avail_q      <= avail_d;
      ir_load_en_q <= wr_fire;
      if (wr_fire) begin
        ir_write_pointer_q <= wptr_q;
        ir_opcode_q        <= wr_opcode[int'(gnt_idx)*OP_W +: OP_W];
        ir_operand_a_q     <= wr_operand_a[int'(gnt_idx)*DATA_W +: DATA_W];
        ir_operand_b_q     <= wr_operand_b[int'(gnt_idx)*DATA_W +: DATA_W];
        last_gnt_q         <= gnt_idx;
      end
      if (rd_fire) ir_read_pointer_q <= rptr_q;
      // Register read data arrives one cycle after the read address is driven.
      rd_pend_q  <= rd_fire;
      rd_valid_q <= rd_pend_q && !flush;
      if (rd_pend_q && !flush) rd_instr_q <= ir_instruction_word;
    end
  end

endmodule
